// File: rtl/data_ram_resp.sv
// Data-memory responder for the core's EX-stage RAM port.
// Serves byte/half/word loads and stores with one-cycle read latency, zero-fills
// the array after reset through a clear FSM, and flags faulting accesses.
module data_ram_resp #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  input  logic        data_we_i,
  input  logic        data_re_i,
  input  logic [2:0]  data_size_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o,
  output logic [31:0] err_addr_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PtrOne = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic                    ready_q;
  logic [31:0]             data_q;
  logic                    err_q;
  logic [7:0]              err_cnt_q;
  logic [31:0]             err_addr_q;

  logic [31:0]             mem [Depth];

  // Address decode
  logic [31:0]             off;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [1:0]              lane;
  logic                    in_range;
  logic                    size_ok;
  logic                    misalign;
  logic                    req;
  logic                    fault;
  logic                    acc_fault;
  logic                    acc_ok;

  // Array write port, shared by the clear sweep and core stores
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_idx;
  logic [3:0]              mem_be;
  logic [31:0]             mem_wdata;

  // Read path
  logic [31:0]             rd_word;
  logic [15:0]             rd_lo;
  logic [31:0]             rd_ext;

  assign off      = data_addr_i - BASE_ADDR;
  assign idx      = off[ADDR_WIDTH+1:2];
  assign lane     = off[1:0];
  assign in_range = (off >> (ADDR_WIDTH + 2)) == 32'd0;
  assign req      = data_we_i | data_re_i;

  // Legal funct3 encodings; unsigned-load encodings are illegal for stores.
  always_comb begin
    size_ok = 1'b0;
    case (data_size_i)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = ~data_we_i;
      default:                size_ok = 1'b0;
    endcase
  end

  // Natural alignment: halves on even lanes, words on lane 0.
  always_comb begin
    misalign = 1'b0;
    case (data_size_i[1:0])
      2'b01:   misalign = lane[0];
      2'b10:   misalign = (lane != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  assign fault     = req & (~in_range | ~size_ok | misalign);
  assign acc_fault = (state_q == StReady) & fault;
  assign acc_ok    = (state_q == StReady) & req & ~fault;

  // Write port select: clear sweep owns the array until the FSM reaches READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_idx   = ptr_q;
      mem_be    = 4'hF;
      mem_wdata = 32'h0;
    end else if (acc_ok && data_we_i) begin
      mem_we = 1'b1;
      case (data_size_i[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << lane;
          mem_wdata = {4{data_i[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << lane;
          mem_wdata = {2{data_i[15:0]}};
        end
        default: begin
          mem_be    = 4'hF;
          mem_wdata = data_i;
        end
      endcase
    end
  end

  // Byte-enabled array write; contents are not reset, the clear FSM zeroes them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Lane select and sign/zero extension of the addressed word.
  always_comb begin
    rd_word = mem[idx];
    rd_lo   = 16'(rd_word >> {lane, 3'b000});
    case (data_size_i)
      3'b000:  rd_ext = {{24{rd_lo[7]}}, rd_lo[7:0]};
      3'b100:  rd_ext = {24'h0, rd_lo[7:0]};
      3'b001:  rd_ext = {{16{rd_lo[15]}}, rd_lo};
      3'b101:  rd_ext = {16'h0, rd_lo};
      default: rd_ext = rd_word;
    endcase
  end

  // Clear FSM: sweep every word once after reset, then serve requests forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StClear;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        StClear: begin
          ptr_q <= ptr_q + PtrOne;
          if (ptr_q == '1) begin
            state_q <= StReady;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StReady;
        end
      endcase
    end
  end

  // Response registers: read data, error pulse, saturating count, first-fault address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q     <= 32'h0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'h0;
      err_addr_q <= 32'h0;
    end else begin
      err_q <= acc_fault;
      if (acc_fault) begin
        data_q <= 32'h0;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
        if (err_cnt_q == 8'h0) begin
          err_addr_q <= data_addr_i;
        end
      end else if (state_q == StClear) begin
        data_q <= 32'h0;
      end else if (data_re_i) begin
        // A simultaneous store wins; the read is treated as absent.
        data_q <= data_we_i ? 32'h0 : rd_ext;
      end
    end
  end

  assign data_o     = data_q;
  assign ready_o    = ready_q;
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp with a 16-word array.
// Reference model keeps a flat byte array and derives faults from alignment arithmetic.
module tb_data_ram_resp;

  localparam int          AW     = 4;
  localparam int          DEPTH  = 16;
  localparam int          NBYTES = 64;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_i = '0;
  logic        data_we_i = 1'b0;
  logic        data_re_i = 1'b0;
  logic [2:0]  data_size_i = '0;
  logic [31:0] data_o;
  logic        ready_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;
  logic [31:0] err_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  mb [NBYTES];
  logic [31:0] m_data;
  logic        m_err;
  logic [7:0]  m_cnt;
  logic [31:0] m_addr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [2:0]  size;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } op_t;

  always #5 clk = ~clk;

  data_ram_resp #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_addr_i (data_addr_i),
    .data_i      (data_i),
    .data_we_i   (data_we_i),
    .data_re_i   (data_re_i),
    .data_size_i (data_size_i),
    .data_o      (data_o),
    .ready_o     (ready_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o),
    .err_addr_o  (err_addr_o)
  );

  function automatic int size_bytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_fault(input logic [31:0] addr, input logic [2:0] size,
                                  input logic we, input logic re);
    logic [31:0] off;
    off = addr - BASE;
    if (!(we || re)) return 1'b0;
    if (off >= NBYTES) return 1'b1;
    if (size == 3'd3 || size > 3'd5) return 1'b1;
    if (we && size[2]) return 1'b1;
    if ((off % size_bytes(size)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] off;
    logic [31:0] v;
    int nb;
    off = addr - BASE;
    nb  = size_bytes(size);
    v   = 32'h0;
    for (int k = 0; k < nb; k++) v = v | (32'(mb[off + k]) << (8 * k));
    if (size == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (size == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    m_data = 32'h0;
    m_err  = 1'b0;
    m_cnt  = 8'h0;
    m_addr = 32'h0;
  endtask

  // Advance the model by one READY-state request.
  task automatic model_step(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic we, input logic re, input logic [2:0] size);
    logic [31:0] off;
    off   = addr - BASE;
    m_err = is_fault(addr, size, we, re);
    if (m_err) begin
      m_data = 32'h0;
      if (m_cnt == 8'd0) m_addr = addr;
      if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    end else begin
      if (re && we) m_data = 32'h0;
      else if (re)  m_data = load_val(addr, size);
      if (we) begin
        for (int k = 0; k < size_bytes(size); k++) mb[off + k] = wdata[8*k +: 8];
      end
    end
  endtask

  // Drive one request for exactly one cycle; outputs are then sampled 1 ns after the edge.
  task automatic do_op(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic we, input logic re, input logic [2:0] size);
    @(negedge clk);
    data_addr_i = addr;
    data_i      = wdata;
    data_we_i   = we;
    data_re_i   = re;
    data_size_i = size;
    model_step(addr, wdata, we, re, size);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    data_we_i = 1'b0;
    data_re_i = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({data_o, ready_o, err_o, err_cnt_o, err_addr_o} !== 74'h0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%08h rdy=%b err=%b cnt=%0d addr=%08h required all zero",
               data_o, ready_o, err_o, err_cnt_o, err_addr_o);
    end
    // A faulting load is held during the whole clear; it must be ignored.
    @(negedge clk);
    data_addr_i = 32'h12;
    data_size_i = 3'd2;
    data_re_i   = 1'b1;
    rst         = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_o === 1'b1) break;
      n_checks++;
      if (err_o !== 1'b0 || data_o !== 32'h0) begin
        n_fail++;
        $display("FAIL clear_ignores_req: got err=%b data=%08h required 0/0", err_o, data_o);
      end
    end
    idle();
    n_checks++;
    if (n !== DEPTH) begin
      n_fail++;
      $display("FAIL ready_latency: got %0d cycles required %0d", n, DEPTH);
    end
    n_checks++;
    if (err_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_err_cnt: got %0d required 0", err_cnt_o);
    end
  endtask

  task automatic test_clear_zero();
    for (int i = 0; i < DEPTH; i++) begin
      do_op(BASE + 32'(4 * i), 32'h0, 1'b0, 1'b1, 3'd2);
      n_checks++;
      if (data_o !== 32'h0 || err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL cleared_word%0d: got data=%08h err=%b required 00000000/0", i, data_o, err_o);
      end
    end
  endtask

  task automatic run_table(input op_t ops [], input string tag);
    foreach (ops[i]) begin
      do_op(ops[i].addr, ops[i].wdata, ops[i].we, ops[i].re, ops[i].size);
      n_checks++;
      if (data_o !== ops[i].exp_data || err_o !== ops[i].exp_err ||
          err_cnt_o !== ops[i].exp_cnt) begin
        n_fail++;
        $display("FAIL %s_step%0d: got data=%08h err=%b cnt=%0d required data=%08h err=%b cnt=%0d",
                 tag, i, data_o, err_o, err_cnt_o, ops[i].exp_data, ops[i].exp_err,
                 ops[i].exp_cnt);
      end
    end
    idle();
  endtask

  task automatic test_load_store();
    op_t ops [];
    ops = new[13];
    ops[0]  = '{32'h10, 32'h8765_4321, 1'b1, 1'b0, 3'd2, 32'h0000_0000, 1'b0, 8'd0};
    ops[1]  = '{32'h13, 32'h0,         1'b0, 1'b1, 3'd0, 32'hFFFF_FF87, 1'b0, 8'd0};
    ops[2]  = '{32'h13, 32'h0,         1'b0, 1'b1, 3'd4, 32'h0000_0087, 1'b0, 8'd0};
    ops[3]  = '{32'h12, 32'h0,         1'b0, 1'b1, 3'd1, 32'hFFFF_8765, 1'b0, 8'd0};
    ops[4]  = '{32'h10, 32'h0,         1'b0, 1'b1, 3'd5, 32'h0000_4321, 1'b0, 8'd0};
    ops[5]  = '{32'h11, 32'h1234_56AB, 1'b1, 1'b0, 3'd0, 32'h0000_4321, 1'b0, 8'd0};
    ops[6]  = '{32'h10, 32'h0,         1'b0, 1'b1, 3'd2, 32'h8765_AB21, 1'b0, 8'd0};
    ops[7]  = '{32'h12, 32'hCAFE_00FF, 1'b1, 1'b0, 3'd1, 32'h8765_AB21, 1'b0, 8'd0};
    ops[8]  = '{32'h10, 32'h0,         1'b0, 1'b1, 3'd2, 32'h00FF_AB21, 1'b0, 8'd0};
    ops[9]  = '{32'h10, 32'h1111_1111, 1'b1, 1'b1, 3'd2, 32'h0000_0000, 1'b0, 8'd0};
    ops[10] = '{32'h10, 32'h0,         1'b0, 1'b1, 3'd2, 32'h1111_1111, 1'b0, 8'd0};
    ops[11] = '{32'h10, 32'h00FF_AB21, 1'b1, 1'b0, 3'd2, 32'h1111_1111, 1'b0, 8'd0};
    ops[12] = '{32'h10, 32'h0,         1'b0, 1'b1, 3'd2, 32'h00FF_AB21, 1'b0, 8'd0};
    run_table(ops, "ldst");
  endtask

  task automatic test_errors();
    op_t ops [];
    ops = new[11];
    ops[0]  = '{32'h12,        32'h0,         1'b0, 1'b1, 3'd2, 32'h0,         1'b1, 8'd1};
    ops[1]  = '{32'h10,        32'h0,         1'b0, 1'b1, 3'd2, 32'h00FF_AB21, 1'b0, 8'd1};
    ops[2]  = '{32'h11,        32'h0000_BEEF, 1'b1, 1'b0, 3'd1, 32'h0,         1'b1, 8'd2};
    ops[3]  = '{32'h10,        32'h0,         1'b0, 1'b1, 3'd2, 32'h00FF_AB21, 1'b0, 8'd2};
    ops[4]  = '{32'h40,        32'hDEAD_BEEF, 1'b1, 1'b0, 3'd2, 32'h0,         1'b1, 8'd3};
    ops[5]  = '{32'h10,        32'h0,         1'b0, 1'b1, 3'd2, 32'h00FF_AB21, 1'b0, 8'd3};
    ops[6]  = '{32'h00,        32'h0,         1'b0, 1'b1, 3'd2, 32'h0,         1'b0, 8'd3};
    ops[7]  = '{32'h10,        32'h0000_0077, 1'b1, 1'b0, 3'd4, 32'h0,         1'b1, 8'd4};
    ops[8]  = '{32'h10,        32'h0,         1'b0, 1'b1, 3'd3, 32'h0,         1'b1, 8'd5};
    ops[9]  = '{32'hFFFF_FFFC, 32'h0,         1'b0, 1'b1, 3'd2, 32'h0,         1'b1, 8'd6};
    ops[10] = '{32'h10,        32'h0,         1'b0, 1'b1, 3'd2, 32'h00FF_AB21, 1'b0, 8'd6};
    run_table(ops, "err");
    n_checks++;
    if (err_addr_o !== 32'h12) begin
      n_fail++;
      $display("FAIL err_addr_first: got %08h required 00000012", err_addr_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      do_op(32'h11 + 32'(4 * (i % 8)), 32'h0, 1'b0, 1'b1, 3'd1);
      n_checks++;
      if (err_o !== 1'b1 || err_cnt_o !== m_cnt) begin
        n_fail++;
        $display("FAIL sat_step%0d: got err=%b cnt=%0d required 1/%0d", i, err_o, err_cnt_o, m_cnt);
      end
    end
    idle();
    n_checks++;
    if (err_cnt_o !== 8'd255 || err_addr_o !== 32'h12) begin
      n_fail++;
      $display("FAIL sat_final: got cnt=%0d addr=%08h required 255/00000012", err_cnt_o, err_addr_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [2:0]  size;
    logic        we;
    logic        re;
    int          r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      case (r % 5)
        0: size = 3'd0;
        1: size = 3'd1;
        2: size = 3'd2;
        3: size = 3'd4;
        default: size = 3'd5;
      endcase
      if (r == 10) size = 3'd3;
      if (r == 11) size = 3'd7;
      r = int'($urandom_range(0, 15));
      if (r == 0)      addr = BASE + 32'h40 + 32'($urandom_range(0, 255));
      else if (r == 1) addr = $urandom;
      else begin
        addr = BASE + 32'($urandom_range(0, NBYTES - 1));
        if (($urandom % 4) != 0) addr = addr & ~32'(size_bytes(size) - 1);
      end
      r = int'($urandom_range(0, 7));
      we = (r >= 1 && r <= 3) || r == 7;
      re = (r >= 4);
      do_op(addr, $urandom, we, re, size);
      n_checks++;
      if (data_o !== m_data || err_o !== m_err || err_cnt_o !== m_cnt || err_addr_o !== m_addr) begin
        n_fail++;
        $display("FAIL rand%0d a=%08h sz=%0d we=%b re=%b: got %08h/%b/%0d/%08h required %08h/%b/%0d/%08h",
                 i, addr, size, we, re, data_o, err_o, err_cnt_o, err_addr_o,
                 m_data, m_err, m_cnt, m_addr);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    logic [31:0] val;
    logic [31:0] held;
    for (int i = 0; i < 10; i++) begin
      addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      val  = $urandom;
      held = m_data;
      do_op(addr, val, 1'b1, 1'b0, 3'd2);
      n_checks++;
      if (data_o !== held) begin
        n_fail++;
        $display("FAIL b2b_hold%0d: got %08h required %08h", i, data_o, held);
      end
      do_op(addr, 32'h0, 1'b0, 1'b1, 3'd2);
      n_checks++;
      if (data_o !== val) begin
        n_fail++;
        $display("FAIL b2b_load%0d: got %08h required %08h", i, data_o, val);
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    int n;
    do_op(32'h08, 32'h5A5A_1234, 1'b1, 1'b0, 3'd2);
    do_op(32'h08, 32'h0, 1'b0, 1'b1, 3'd2);
    idle();
    // Assert reset away from any edge: outputs must clear without a clock.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({data_o, ready_o, err_o, err_cnt_o, err_addr_o} !== 74'h0) begin
      n_fail++;
      $display("FAIL async_reset: got data=%08h rdy=%b err=%b cnt=%0d addr=%08h required all zero",
               data_o, ready_o, err_o, err_cnt_o, err_addr_o);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || err_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL midclear_reset: got rdy=%b cnt=%0d required 0/0", ready_o, err_cnt_o);
    end
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_o === 1'b1) break;
    end
    n_checks++;
    if (n !== DEPTH) begin
      n_fail++;
      $display("FAIL ready_latency_restart: got %0d cycles required %0d", n, DEPTH);
    end
    do_op(32'h08, 32'h0, 1'b0, 1'b1, 3'd2);
    n_checks++;
    if (data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL recleared_word: got %08h required 00000000", data_o);
    end
    do_op(32'h06, 32'h0, 1'b0, 1'b1, 3'd2);
    n_checks++;
    if (err_o !== 1'b1 || err_cnt_o !== 8'd1 || err_addr_o !== 32'h06) begin
      n_fail++;
      $display("FAIL err_after_reset: got err=%b cnt=%0d addr=%08h required 1/1/00000006",
               err_o, err_cnt_o, err_addr_o);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_clear_zero();
    test_load_store();
    test_errors();
    test_saturation();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
